puf_crp_sequencer: RTL
======================

// Module: puf_crp_sequencer
// PURPOSE
//  Parametrised challenge-response sequencer between the byte-wide UART RX/TX cores and an arbiter PUF.
//  Assembles a CH_W-bit challenge from RX bytes and evaluates the PUF NUM_EVAL times per challenge.
//  Majority-votes each response bit, then streams the voted RSP_W-bit response back as TX bytes.
//  Replaces the fixed 16-bit / single-shot / free-running-delay challenge path; flags unstable responses.
// PARAMETERS
//  CH_W      16  challenge width; multiple of 8, 8..64
//  RSP_W     16  response width; multiple of 8, 8..64
//  NUM_EVAL   5  PUF evaluations per challenge; odd, 1..15
//  SETTLE     4  cycles trigger held high (and low) per evaluation; >=1
// PORTS
//  clk            in   1      system clock
//  rst            in   1      asynchronous reset, active-high
//  rx_data        in   8      received byte
//  rx_valid       in   1      1-cycle strobe, rx_data valid
//  rx_overrun     out  1      1-cycle pulse: rx_valid seen outside COLLECT, byte dropped
//  puf_challenge  out  CH_W   challenge applied to PUF, stable for the whole evaluation series
//  puf_trigger    out  1      PUF launch/enable
//  puf_response   in   RSP_W  PUF arbiter outputs
//  tx_data        out  8      byte to transmit
//  tx_valid       out  1      tx_data valid; held until tx_ready
//  tx_ready       in   1      TX core accepts byte when tx_valid & tx_ready
//  busy           out  1      high in every state except COLLECT
//  unstable       out  1      last voted response had >=1 bit not unanimous across NUM_EVAL samples
// BEHAVIOUR
//  Reset: state=COLLECT, byte count 0; all outputs 0 (puf_challenge=0, trigger=0, tx_valid=0, unstable=0).
//  Reset mid-operation aborts immediately: partial challenge, counters and pending TX byte discarded.
//  COLLECT: each rx_valid shifts rx_data in MSB-first (first byte -> challenge[CH_W-1:CH_W-8]).
//   On capture of byte CH_W/8: register challenge to puf_challenge, clear vote counters, go EVAL_HI.
//  EVAL_HI: puf_trigger=1 for SETTLE cycles; puf_response sampled on the clock edge ending the last
//   EVAL_HI cycle; per-bit counter (4 bits) increments where the sampled bit is 1. Then EVAL_LO.
//  EVAL_LO: puf_trigger=0 for SETTLE cycles (PUF re-arm). If evaluations done == NUM_EVAL -> VOTE, else EVAL_HI.
//  VOTE (1 cycle): resp[i] = (cnt[i] > NUM_EVAL/2); unstable <= |(cnt[i]!=0 && cnt[i]!=NUM_EVAL).
//  SEND: bytes of resp MSB-first; tx_valid=1 with tx_data stable until tx_valid&tx_ready;
//   next byte presented the cycle after acceptance (no bubble-free requirement beyond that).
//   After the last byte's handshake -> COLLECT; tx_valid=0 next cycle.
//  Latency: last RX byte edge -> tx_valid high = 2*SETTLE*NUM_EVAL + 1 cycles (41 at defaults).
//  rx_valid in any state but COLLECT: byte dropped, rx_overrun pulses the following cycle;
//   includes the cycle of the final TX handshake (COLLECT starts the cycle after).
//  puf_challenge holds its value after SEND until the next challenge completes.
//  unstable holds until the next VOTE or reset.
// CONFIGURATION
//  CRP_GRAY_EN defined: puf_challenge = assembled ^ (assembled >> 1) (binary-to-Gray, reduces
//   adjacent-challenge correlation). Undefined: puf_challenge = assembled challenge unchanged.
// TESTING (PUF stub: response = puf_challenge ^ 16'hA5A5, sampled while trigger high; defaults)
//  1 No macro, RX 0x12,0x34 -> puf_challenge=0x1234; TX 0xB7 then 0x91; unstable=0; tx_valid 41 cycles after byte 2.
//  2 CRP_GRAY_EN, RX 0x00,0x05 -> puf_challenge=0x0007; TX 0xA5,0xA2.
//  3 Stub flips resp bit0 on evals 2,4 (2 of 5) -> TX unchanged 0xB7,0x91, unstable=1;
//    flips on 3 of 5 -> TX 0xB7,0x90, unstable=1.
//  4 tx_ready low 10 cycles during first byte -> tx_valid high, tx_data=0xB7 stable; no byte lost or duplicated.
//  5 rx_valid pulsed during EVAL_HI -> rx_overrun 1 cycle later; response unaffected; busy=1 throughout.
//  6 rst asserted in EVAL_LO of eval 3 -> all outputs 0 asynchronously; next RX 0xAB,0xCD -> TX 0x0E,0x68.

Source files
------------

// File: rtl/puf_crp_sequencer.sv
// Challenge-response sequencer: RX bytes -> challenge, NUM_EVAL PUF evaluations, majority vote -> TX bytes.
// Optional CRP_GRAY_EN: apply binary-to-Gray mapping to the challenge driven onto the PUF.
module puf_crp_sequencer #(
   parameter int CH_W     = 16,
   parameter int RSP_W    = 16,
   parameter int NUM_EVAL = 5,
   parameter int SETTLE   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_overrun,
   output logic [CH_W-1:0]  puf_challenge,
   output logic             puf_trigger,
   input  logic [RSP_W-1:0] puf_response,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             unstable
);

   localparam int NB_CH  = CH_W / 8;
   localparam int NB_RSP = RSP_W / 8;
   localparam int SW     = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {COLLECT, EVAL_HI, EVAL_LO, VOTE, SEND} state_t;

   state_t            state, state_nx;
   logic [CH_W-1:0]   assembled, assembled_nx, challenge_nx;
   logic [3:0]        byte_cnt;
   logic [SW-1:0]     settle_cnt;
   logic [3:0]        eval_cnt;
   logic [3:0]        tx_cnt;
   logic [3:0]        vote_cnt [RSP_W];
   logic [RSP_W-1:0]  resp_sh, resp_vote;
   logic              unstable_vote;
   logic              settle_done, last_byte, tx_last;

   assign settle_done = (settle_cnt == SW'(SETTLE - 1));
   assign last_byte   = (byte_cnt == 4'(NB_CH - 1));
   assign tx_last     = (tx_cnt == 4'(NB_RSP - 1));
   assign tx_data     = resp_sh[RSP_W-1 -: 8];

   always_comb begin
      assembled_nx = (assembled << 8) | CH_W'(rx_data);
`ifdef CRP_GRAY_EN
      challenge_nx = assembled_nx ^ (assembled_nx >> 1);
`else
      challenge_nx = assembled_nx;
`endif
   end

   always_comb begin
      resp_vote     = '0;
      unstable_vote = 1'b0;
      for (int unsigned i = 0; i < RSP_W; i++) begin
         resp_vote[i]  = (vote_cnt[i] > 4'(NUM_EVAL / 2));
         unstable_vote = unstable_vote | ((vote_cnt[i] != '0) && (vote_cnt[i] != 4'(NUM_EVAL)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      puf_trigger = 1'b0;
      tx_valid    = 1'b0;
      busy        = 1'b1;
      case (state)
         COLLECT: begin
            busy = 1'b0;
            if (rx_valid && last_byte) state_nx = EVAL_HI;
         end
         EVAL_HI: begin
            puf_trigger = 1'b1;
            if (settle_done) state_nx = EVAL_LO;
         end
         EVAL_LO: begin
            if (settle_done) state_nx = (eval_cnt == 4'(NUM_EVAL)) ? VOTE : EVAL_HI;
         end
         VOTE:    state_nx = SEND;
         SEND: begin
            tx_valid = 1'b1;
            if (tx_ready && tx_last) state_nx = COLLECT;
         end
         default: state_nx = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_overrun    <= 1'b0;
         puf_challenge <= '0;
         unstable      <= 1'b0;
         assembled     <= '0;
         byte_cnt      <= '0;
         settle_cnt    <= '0;
         eval_cnt      <= '0;
         tx_cnt        <= '0;
         resp_sh       <= '0;
         for (int unsigned i = 0; i < RSP_W; i++) vote_cnt[i] <= '0;
      end else begin
         rx_overrun <= rx_valid && (state != COLLECT);
         case (state)
            COLLECT: begin
               if (rx_valid) begin
                  assembled <= assembled_nx;
                  if (last_byte) begin
                     byte_cnt      <= '0;
                     puf_challenge <= challenge_nx;
                     eval_cnt      <= '0;
                     settle_cnt    <= '0;
                     for (int unsigned i = 0; i < RSP_W; i++) vote_cnt[i] <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                  end
               end
            end
            EVAL_HI: begin
               if (settle_done) begin
                  // response captured on the edge that ends the last high cycle
                  settle_cnt <= '0;
                  eval_cnt   <= eval_cnt + 4'd1;
                  for (int unsigned i = 0; i < RSP_W; i++)
                     vote_cnt[i] <= vote_cnt[i] + 4'(puf_response[i]);
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            EVAL_LO: begin
               if (settle_done) settle_cnt <= '0;
               else             settle_cnt <= settle_cnt + SW'(1);
            end
            VOTE: begin
               resp_sh  <= resp_vote;
               unstable <= unstable_vote;
               tx_cnt   <= '0;
            end
            SEND: begin
               if (tx_ready) begin
                  resp_sh <= resp_sh << 8;
                  tx_cnt  <= tx_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
